d_mem_arbiter: RTL and testbench

// Two-port arbiter/sequencer in front of the single-port data memory. Port 0 is the

---
 rtl/d_mem_arbiter.sv | 135 +++++++++++++
 tb/tb_d_mem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/d_mem_arbiter.sv
// d_mem_arbiter: serialises core (port 0) and debug/loader (port 1) accesses to a single-port
// data memory as IDLE -> ACCESS -> RESP, with registered memory controls and one-cycle acks.
module d_mem_arbiter #(
    parameter int unsigned DEPTH      = 256,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [31:0] mem_address,
    output logic [31:0] write_data,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] read_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic [31:0] DepthW = 32'(DEPTH);

    state_e      state_q;
    logic        lastGrant_q;
    logic        gnt_q;
    logic        we_q;
    logic        err_q;

    logic        winner;
    logic        selWe;
    logic        selOor;
    logic [31:0] selAddr;
    logic [31:0] selWdata;

    // On a tie, round-robin hands the grant to whichever port did not win last time.
    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
            winner = FIXED_PRIO ? 1'b0 : ~lastGrant_q;
        end else if (req1) begin
            winner = 1'b1;
        end
        selWe    = winner ? we1 : we0;
        selAddr  = winner ? addr1 : addr0;
        selWdata = winner ? wdata1 : wdata0;
        selOor   = (selAddr >= DepthW);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b1;
            gnt_q       <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            err0        <= 1'b0;
            err1        <= 1'b0;
            rdata0      <= '0;
            rdata1      <= '0;
            mem_address <= '0;
            write_data  <= '0;
            MemRead     <= 1'b0;
            MemWrite    <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            err0 <= 1'b0;
            err1 <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt_q       <= winner;
                        we_q        <= selWe;
                        err_q       <= selOor;
                        lastGrant_q <= winner;
                        // Out-of-range accesses skip the memory entirely and answer at once.
                        if (selOor) begin
                            ack0    <= ~winner;
                            ack1    <= winner;
                            err0    <= ~winner;
                            err1    <= winner;
                            state_q <= RESP;
                        end else begin
                            mem_address <= selAddr;
                            write_data  <= selWdata;
                            MemRead     <= ~selWe;
                            MemWrite    <= selWe;
                            state_q     <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    MemRead  <= 1'b0;
                    MemWrite <= 1'b0;
                    if (!we_q) begin
                        if (gnt_q) begin
                            rdata1 <= read_data;
                        end else begin
                            rdata0 <= read_data;
                        end
                    end
                    ack0    <= ~gnt_q;
                    ack1    <= gnt_q;
                    err0    <= ~gnt_q & err_q;
                    err1    <= gnt_q & err_q;
                    state_q <= RESP;
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_d_mem_arbiter.sv
// tb_d_mem_arbiter: drives a round-robin and a fixed-priority arbiter, each with its own memory,
// and compares acks, latencies, errors and read data against a transaction-level reference model.
module tb_d_mem_arbiter;

    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req0 [2];
    logic        req1 [2];
    logic        we0 [2];
    logic        we1 [2];
    logic [31:0] addr0 [2];
    logic [31:0] addr1 [2];
    logic [31:0] wdata0 [2];
    logic [31:0] wdata1 [2];
    logic        ack0 [2];
    logic        ack1 [2];
    logic        err0 [2];
    logic        err1 [2];
    logic [31:0] rdata0 [2];
    logic [31:0] rdata1 [2];
    logic [31:0] memAddress [2];
    logic [31:0] writeData [2];
    logic [31:0] readData [2];
    logic        memRead [2];
    logic        memWrite [2];

    logic [31:0] mem [2][DEPTH] = '{default: '0};
    logic [31:0] refMem [2][DEPTH] = '{default: '0};
    logic [31:0] expRdata [2][2];
    int          lastGrant [2];

    int vectors = 0;
    int miscompares = 0;

    d_mem_arbiter #(.DEPTH(DEPTH), .FIXED_PRIO(1'b0)) dutRr (
        .clk(clk), .rst_n(rst_n),
        .req0(req0[0]), .req1(req1[0]), .we0(we0[0]), .we1(we1[0]),
        .addr0(addr0[0]), .addr1(addr1[0]), .wdata0(wdata0[0]), .wdata1(wdata1[0]),
        .ack0(ack0[0]), .ack1(ack1[0]), .err0(err0[0]), .err1(err1[0]),
        .rdata0(rdata0[0]), .rdata1(rdata1[0]),
        .mem_address(memAddress[0]), .write_data(writeData[0]),
        .MemRead(memRead[0]), .MemWrite(memWrite[0]), .read_data(readData[0])
    );

    d_mem_arbiter #(.DEPTH(DEPTH), .FIXED_PRIO(1'b1)) dutFixed (
        .clk(clk), .rst_n(rst_n),
        .req0(req0[1]), .req1(req1[1]), .we0(we0[1]), .we1(we1[1]),
        .addr0(addr0[1]), .addr1(addr1[1]), .wdata0(wdata0[1]), .wdata1(wdata1[1]),
        .ack0(ack0[1]), .ack1(ack1[1]), .err0(err0[1]), .err1(err1[1]),
        .rdata0(rdata0[1]), .rdata1(rdata1[1]),
        .mem_address(memAddress[1]), .write_data(writeData[1]),
        .MemRead(memRead[1]), .MemWrite(memWrite[1]), .read_data(readData[1])
    );

    for (genvar g = 0; g < 2; g++) begin : gMem
        assign readData[g] = (memRead[g] && memAddress[g] < 32'(DEPTH)) ?
                             mem[g][memAddress[g][7:0]] : 32'h0;
        always @(posedge clk) begin
            if (memWrite[g] && memAddress[g] < 32'(DEPTH)) begin
                mem[g][memAddress[g][7:0]] <= writeData[g];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                checkOutput($sformatf("d%0d_ack_onehot", d), 32'(ack0[d] & ack1[d]), 32'd0);
                checkOutput($sformatf("d%0d_rd_wr_excl", d), 32'(memRead[d] & memWrite[d]), 32'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic resetAndCheck();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            lastGrant[d]   = 1;
            expRdata[d][0] = '0;
            expRdata[d][1] = '0;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("d%0d_rst_ack", d), {30'd0, ack1[d], ack0[d]}, 32'd0);
            checkOutput($sformatf("d%0d_rst_err", d), {30'd0, err1[d], err0[d]}, 32'd0);
            checkOutput($sformatf("d%0d_rst_rdata0", d), rdata0[d], 32'd0);
            checkOutput($sformatf("d%0d_rst_rdata1", d), rdata1[d], 32'd0);
            checkOutput($sformatf("d%0d_rst_memctl", d), {30'd0, memWrite[d], memRead[d]}, 32'd0);
            checkOutput($sformatf("d%0d_rst_addr", d), memAddress[d], 32'd0);
            checkOutput($sformatf("d%0d_rst_wdata", d), writeData[d], 32'd0);
        end
    endtask

    // One transaction round: the model decides service order and latency from the arbitration rules.
    task automatic applyStimulus(input int d, input bit v0, input bit v1, input bit w0, input bit w1,
                                 input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] wd0, input logic [31:0] wd1);
        bit          v [2];
        bit          w [2];
        logic [31:0] a [2];
        logic [31:0] wd [2];
        int          expLat [2];
        bit          expErr [2];
        int          lat [2];
        int          ackCnt [2];
        logic        errSeen [2];
        logic [31:0] rdSeen [2];
        int          order [2];
        int          nReq;
        int          tEnd;
        int          expWrites;
        int          writes;
        int          cyc;
        v[0] = v0; v[1] = v1; w[0] = w0; w[1] = w1;
        a[0] = a0; a[1] = a1; wd[0] = wd0; wd[1] = wd1;
        expLat = '{0, 0};
        expErr = '{0, 0};
        if (v0 && v1) begin
            order[0] = (d == 1) ? 0 : ((lastGrant[d] == 0) ? 1 : 0);
            order[1] = 1 - order[0];
            nReq = 2;
        end else begin
            order[0] = v1 ? 1 : 0;
            order[1] = 0;
            nReq = 1;
        end
        tEnd = 0;
        expWrites = 0;
        for (int k = 0; k < nReq; k++) begin
            int p;
            bit oor;
            p = order[k];
            oor = (a[p] >= 32'(DEPTH));
            tEnd = tEnd + ((k > 0) ? 1 : 0) + (oor ? 1 : 2);
            expLat[p] = tEnd;
            expErr[p] = oor;
            lastGrant[d] = p;
            if (!oor && w[p]) begin
                refMem[d][a[p][7:0]] = wd[p];
                expWrites++;
            end else if (!oor) begin
                expRdata[d][p] = refMem[d][a[p][7:0]];
            end
        end

        @(posedge clk); #1;
        req0[d] = v0; we0[d] = w0; addr0[d] = a0; wdata0[d] = wd0;
        req1[d] = v1; we1[d] = w1; addr1[d] = a1; wdata1[d] = wd1;
        lat = '{-1, -1};
        ackCnt = '{0, 0};
        errSeen = '{1'b0, 1'b0};
        rdSeen = '{32'd0, 32'd0};
        writes = 0;
        cyc = 0;
        for (int t = 0; t < 12; t++) begin
            @(posedge clk); #1;
            if (ackCnt[0] > 0) req0[d] = 1'b0;
            if (ackCnt[1] > 0) req1[d] = 1'b0;
            if ((ackCnt[0] > 0 || !v0) && (ackCnt[1] > 0 || !v1)) break;
            @(negedge clk);
            cyc++;
            if (memWrite[d]) writes++;
            if (ack0[d]) begin
                ackCnt[0]++;
                if (lat[0] < 0) begin lat[0] = cyc; errSeen[0] = err0[d]; rdSeen[0] = rdata0[d]; end
            end
            if (ack1[d]) begin
                ackCnt[1]++;
                if (lat[1] < 0) begin lat[1] = cyc; errSeen[1] = err1[d]; rdSeen[1] = rdata1[d]; end
            end
        end
        req0[d] = 1'b0;
        req1[d] = 1'b0;

        for (int p = 0; p < 2; p++) begin
            checkOutput($sformatf("d%0d_p%0d_ack_count", d, p), 32'(ackCnt[p]), 32'(v[p]));
            if (v[p]) begin
                checkOutput($sformatf("d%0d_p%0d_latency", d, p), 32'(lat[p]), 32'(expLat[p]));
                checkOutput($sformatf("d%0d_p%0d_err", d, p), 32'(errSeen[p]), 32'(expErr[p]));
                checkOutput($sformatf("d%0d_p%0d_rdata_at_ack", d, p), rdSeen[p], expRdata[d][p]);
            end
        end
        checkOutput($sformatf("d%0d_rdata0_held", d), rdata0[d], expRdata[d][0]);
        checkOutput($sformatf("d%0d_rdata1_held", d), rdata1[d], expRdata[d][1]);
        checkOutput($sformatf("d%0d_write_cycles", d), 32'(writes), 32'(expWrites));
    endtask

    function automatic logic [31:0] randAddr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 7) return 32'($urandom_range(0, 15));
        if (r == 7) return 32'($urandom_range(250, 255));
        if (r == 8) return 32'(256 + $urandom_range(0, 3));
        return $urandom | 32'h0000_0100;
    endfunction

    initial begin
        int n0;
        int ack1Cyc;
        int cyc;
        bit lastAck0;
        logic [31:0] rdAtAck1;
        for (int d = 0; d < 2; d++) begin
            req0[d] = 0; req1[d] = 0; we0[d] = 0; we1[d] = 0;
            addr0[d] = '0; addr1[d] = '0; wdata0[d] = '0; wdata1[d] = '0;
        end
        resetAndCheck();

        // Write then read back on the core port.
        applyStimulus(0, 1, 0, 1, 0, 32'd5, 32'd0, 32'hDEADBEEF, 32'd0);
        checkOutput("t1_mem_address", memAddress[0], 32'd5);
        checkOutput("t1_write_data", writeData[0], 32'hDEADBEEF);
        applyStimulus(0, 1, 0, 0, 0, 32'd5, 32'd0, 32'd0, 32'd0);
        checkOutput("t1_readback", rdata0[0], 32'hDEADBEEF);

        // Simultaneous reads in round-robin mode, then alternation after a lone port-0 grant.
        resetAndCheck();
        applyStimulus(0, 1, 1, 0, 0, 32'd5, 32'd5, 32'd0, 32'd0);
        checkOutput("t2_rdata1", rdata1[0], 32'hDEADBEEF);
        applyStimulus(0, 1, 0, 1, 0, 32'd1, 32'd0, 32'h1111_0001, 32'd0);
        applyStimulus(0, 1, 1, 0, 0, 32'd1, 32'd5, 32'd0, 32'd0);
        applyStimulus(0, 1, 1, 0, 0, 32'd5, 32'd1, 32'd0, 32'd0);

        // Fixed priority: port 0 keeps requesting, port 1 waits until it stops.
        @(posedge clk); #1;
        req0[1] = 1; we0[1] = 0; addr0[1] = 32'd3;
        req1[1] = 1; we1[1] = 0; addr1[1] = 32'd4;
        n0 = 0; ack1Cyc = -1; cyc = 0; lastAck0 = 0; rdAtAck1 = '0;
        for (int k = 0; k < 20 && ack1Cyc < 0; k++) begin
            @(posedge clk); #1;
            if (lastAck0 && n0 == 3) req0[1] = 1'b0;
            @(negedge clk);
            cyc++;
            lastAck0 = ack0[1];
            if (ack0[1]) n0++;
            if (ack1[1]) begin ack1Cyc = cyc; rdAtAck1 = rdata1[1]; end
        end
        @(posedge clk); #1;
        req0[1] = 0; req1[1] = 0;
        expRdata[1][0] = refMem[1][3];
        expRdata[1][1] = refMem[1][4];
        checkOutput("t3_port0_grants", 32'(n0), 32'd3);
        checkOutput("t3_port1_ack_cycle", 32'(ack1Cyc), 32'd11);
        checkOutput("t3_port1_rdata", rdAtAck1, expRdata[1][1]);

        // Out-of-range write from the debug port, then an in-range read from it.
        applyStimulus(0, 0, 1, 0, 1, 32'd0, 32'd256, 32'd0, 32'h1234_5678);
        checkOutput("t4_word0_intact", mem[0][0], refMem[0][0]);
        applyStimulus(0, 0, 1, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0);

        // Reset asserted in the middle of a write access.
        @(posedge clk); #1;
        req0[0] = 1; we0[0] = 1; addr0[0] = 32'd7; wdata0[0] = 32'hA5A5_0007;
        @(posedge clk); #1;
        checkOutput("t5_memwrite_in_access", 32'(memWrite[0]), 32'd1);
        checkOutput("t5_addr_in_access", memAddress[0], 32'd7);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_memwrite_after_reset", 32'(memWrite[0]), 32'd0);
        checkOutput("t5_addr_after_reset", memAddress[0], 32'd0);
        checkOutput("t5_ack_after_reset", 32'(ack0[0]), 32'd0);
        @(posedge clk); #1;
        req0[0] = 0; we0[0] = 0;
        checkOutput("t5_write_not_committed", mem[0][7], refMem[0][7]);
        resetAndCheck();
        applyStimulus(0, 1, 0, 0, 0, 32'd7, 32'd0, 32'd0, 32'd0);

        // Randomised traffic on both arbiters.
        for (int i = 0; i < 80; i++) begin
            int d;
            bit v0r, v1r;
            d = int'($urandom_range(0, 1));
            v0r = 1'($urandom_range(0, 1));
            v1r = 1'($urandom_range(0, 1));
            if (!v0r && !v1r) v0r = 1'b1;
            applyStimulus(d, v0r, v1r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          randAddr(), randAddr(), $urandom, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
